mux_sel_arbiter: RTL and testbench
==================================

Name: mux_sel_arbiter

Overview:
Round-robin arbiter that shares one N:1 multiplexed datapath (built from MUX1_2x1 trees) among NUM_REQ requesters.
- Drives the mux select and a one-hot grant.
- Enforces a one-cycle dead gap on every handover.
- Optionally preempts an owner that exceeds MAX_HOLD cycles while others wait.
- Sits between requesting units (e.g. fetch/load-store) and a shared bus or register-file port mux.

Parameters:
NUM_REQ, 4, number of requesters (2..16).
SEL_W, 2, select width; must equal clog2(NUM_REQ), minimum 1.
MAX_HOLD, 8, maximum consecutive owned cycles before forced release when contended; 0 disables preemption.

Ports:
CLK  input  1  clock, all state on rising edge.
RST  input  1  synchronous, active-high reset.
REQ  input  NUM_REQ  per-requester request level; held high while the requester wants or owns the mux.
DONE  input  NUM_REQ  per-requester release pulse; only the current owner's bit is honoured.
GNT  output  NUM_REQ  one-hot grant, registered; all-zero when no owner.
SEL  output  SEL_W  mux select, registered; index of current or last owner.
BUSY  output  1  high while an owner holds GNT.
PREEMPT  output  1  one-cycle pulse in the cycle the forced release takes effect.

Behaviour:
- Reset: RST sampled high at a CLK edge sets GNT=0, SEL=0, BUSY=0, PREEMPT=0, state=IDLE, ptr=0 (requester 0 highest priority), hold_cnt=0. This applies identically mid-grant; no partial handover survives.
- States: IDLE, OWN, GAP.
- Arbitration in IDLE or GAP:
  - winner = first i with REQ[i]=1, scanning ptr, ptr+1, ... mod NUM_REQ.
  - If a winner exists: next edge GNT=onehot(winner), SEL=winner, BUSY=1, hold_cnt=0, state=OWN.
  - REQ->GNT latency is 1 cycle from IDLE.
  - GAP always lasts exactly one cycle. With no request it goes to IDLE.
- OWN:
  - Normal release: DONE[owner]=1, or REQ[owner]=0.
  - Next edge: GNT=0, BUSY=0, ptr=(owner+1) mod NUM_REQ, state=GAP. SEL holds its value.
- Preemption (MAX_HOLD>0):
  - Triggers when hold_cnt==MAX_HOLD-1 and any other REQ bit is set.
  - Same transition as normal release, plus PREEMPT=1 for that one cycle.
  - Owner keeps GNT for exactly MAX_HOLD cycles.
  - Without contention, hold_cnt saturates at MAX_HOLD-1 and no preemption occurs.
- hold_cnt increments each OWN cycle and saturates. Width is clog2(MAX_HOLD+1).
- DONE bits of non-owners are ignored in every state. DONE in IDLE/GAP is ignored.
- Simultaneous DONE and preemption condition: treat as normal release; PREEMPT=0.
- Handover timing: release detected at edge t gives GNT=0 at t+1 (GAP) and the new GNT at t+2. GNT is never nonzero in two consecutive cycles for different owners.
- SEL changes only on entry to OWN, so the mux select is stable for the whole grant plus the gap.
- GNT is always one-hot or zero. BUSY equals the OR of GNT.
- NUM_REQ=2: SEL_W=1, and SEL drives MUX1_2x1 S directly.

Decomposition:
- Shared definitions include:
  - state encodings ARB_IDLE=2'd0, ARB_OWN=2'd1, ARB_GAP=2'd2;
  - a clog2 constant function used for SEL_W and hold_cnt width.
- Sub-module rr_pick:
  - combinational rotating-priority encoder;
  - inputs REQ and ptr; outputs a valid flag and the winner index;
  - verified standalone for all ptr values.

Test Plan:
1. RST=1 for 2 cycles with REQ=4'b1111 -> GNT=0, SEL=0, BUSY=0, PREEMPT=0. Release RST -> GNT=4'b0001 one cycle later.
2. REQ=4'b0100 at cycle 0 -> GNT=4'b0100, SEL=2 at cycle 1. DONE=4'b0010 at cycle 3 is ignored. DONE=4'b0100 at cycle 5 -> GNT=0 at cycle 6, ptr=3.
3. REQ=4'b1111 steady, each owner pulses DONE on its 2nd owned cycle -> grant order 0,1,2,3,0 with SEL tracking and one zero-GNT cycle between each.
4. MAX_HOLD=8, REQ=4'b0011, owner 0 never sends DONE -> GNT[0] high exactly 8 cycles, then PREEMPT=1 with GNT=0, then GNT=4'b0010, SEL=1.
5. MAX_HOLD=8, REQ=4'b0001 only, held 20 cycles -> GNT[0] stays high throughout, PREEMPT never asserts.
6. RST pulsed for one cycle while GNT=4'b1000 -> next cycle GNT=0, SEL=0, ptr=0. With REQ=4'b1001 the following grant is 4'b0001.

Source files
------------

// File: rtl/mux_sel_arbiter_pkg.sv
// Shared definitions for the round-robin mux-select arbiter: state encoding
// and the width helpers used for the select and hold-counter sizing.
package mux_sel_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN  = 2'd1,
        ARB_GAP  = 2'd2
    } arb_state_e;

    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

    function automatic int max1(input int value);
        return (value < 1) ? 1 : value;
    endfunction

endpackage

// File: rtl/mux_sel_arbiter_rr_pick.sv
// Combinational rotating-priority encoder: returns the first requester at or
// after ptr (wrapping modulo NUM_REQ) and a flag saying whether one exists.
module mux_sel_arbiter_rr_pick
    import mux_sel_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               valid,
    output logic [SEL_W-1:0]   win
);

    always_comb begin
        int                 idx;
        logic [NUM_REQ-1:0] req_sh;
        valid  = 1'b0;
        win    = '0;
        idx    = 0;
        req_sh = '0;
        // Scan from the farthest offset down so the nearest requester wins last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            req_sh = req >> idx;
            if (req_sh[0]) begin
                valid = 1'b1;
                win   = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin owner of a shared N:1 mux: registered one-hot grant and select,
// a one-cycle dead gap on every handover, and optional hold-time preemption.
module mux_sel_arbiter
    import mux_sel_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int SEL_W    = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_REQ-1:0] REQ,
    input  logic [NUM_REQ-1:0] DONE,
    output logic [NUM_REQ-1:0] GNT,
    output logic [SEL_W-1:0]   SEL,
    output logic               BUSY,
    output logic               PREEMPT
);

    localparam int HC_W = max1(clog2(MAX_HOLD + 1));
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REQ - 1);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               busy_q, busy_d;
    logic               preempt_q, preempt_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [HC_W-1:0]    hold_q, hold_d;

    logic               pick_valid;
    logic [SEL_W-1:0]   pick_win;
    logic               owner_rel;
    logic               force_rel;
    logic               contended;

    mux_sel_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .SEL_W   (SEL_W)
    ) u_pick (
        .req   (REQ),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .win   (pick_win)
    );

    // Only the current owner's DONE/REQ bits matter; sel_q names the owner while in OWN.
    assign contended = |(REQ & ~gnt_q);
    assign owner_rel = DONE[sel_q] | ~REQ[sel_q];
    assign force_rel = (MAX_HOLD > 0) && (hold_q == HOLD_LAST) && contended;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        preempt_d = 1'b0;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        case (state_q)
            ARB_IDLE, ARB_GAP: begin
                if (pick_valid) begin
                    gnt_d   = NUM_REQ'(1) << pick_win;
                    sel_d   = pick_win;
                    busy_d  = 1'b1;
                    hold_d  = '0;
                    state_d = ARB_OWN;
                end else begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = ARB_IDLE;
                end
            end
            ARB_OWN: begin
                if (owner_rel || force_rel) begin
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    ptr_d     = (sel_q == LAST_IDX) ? '0 : sel_q + SEL_W'(1);
                    preempt_d = ~owner_rel;
                    state_d   = ARB_GAP;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + HC_W'(1);
                end
            end
            default: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ARB_IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
            ptr_q     <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
        end
    end

    assign GNT     = gnt_q;
    assign SEL     = sel_q;
    assign BUSY    = busy_q;
    assign PREEMPT = preempt_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter: a cycle table of inputs and hand-computed
// registered outputs, followed by hold-time sequences for preemption corners.
module tb_mux_sel_arbiter;

    logic       CLK;
    logic       RST;
    logic [3:0] REQ;
    logic [3:0] DONE;
    logic [3:0] GNT;
    logic [1:0] SEL;
    logic       BUSY;
    logic       PREEMPT;

    int n_tests;
    int n_fail;

    mux_sel_arbiter #(
        .NUM_REQ  (4),
        .SEL_W    (2),
        .MAX_HOLD (8)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .REQ     (REQ),
        .DONE    (DONE),
        .GNT     (GNT),
        .SEL     (SEL),
        .BUSY    (BUSY),
        .PREEMPT (PREEMPT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       pre;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [3:0] req, input logic [3:0] done,
                       input logic [3:0] gnt, input logic [1:0] sel, input logic busy,
                       input logic pre);
        vec_t v;
        v.rst = rst; v.req = req; v.done = done;
        v.gnt = gnt; v.sel = sel; v.busy = busy; v.pre = pre;
        vecs.push_back(v);
    endtask

    // Apply inputs, take one rising edge, sample 1 time unit later.
    task automatic step(input logic rst, input logic [3:0] req, input logic [3:0] done);
        RST  = rst;
        REQ  = req;
        DONE = done;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [3:0] gnt,
                         input logic [1:0] sel, input logic busy, input logic pre);
        n_tests++;
        if (GNT !== gnt || SEL !== sel || BUSY !== busy || PREEMPT !== pre) begin
            n_fail++;
            $display("FAIL %s[%0d]: got GNT=%b SEL=%0d BUSY=%b PREEMPT=%b, want GNT=%b SEL=%0d BUSY=%b PREEMPT=%b",
                     name, idx, GNT, SEL, BUSY, PREEMPT, gnt, sel, busy, pre);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        RST  = 1'b1;
        REQ  = '0;
        DONE = '0;

        //   rst  req      done     gnt      sel busy pre
        // Reset held with all requesting, then first grant goes to 0.
        add(1, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0);
        add(1, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b1111, 4'b0000, 4'b0001, 0, 1, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        // Single requester 2; foreign DONE ignored; own DONE releases, ptr -> 3.
        add(0, 4'b0100, 4'b0000, 4'b0100, 2, 1, 0);
        add(0, 4'b0100, 4'b0000, 4'b0100, 2, 1, 0);
        add(0, 4'b0100, 4'b0000, 4'b0100, 2, 1, 0);
        add(0, 4'b0100, 4'b0010, 4'b0100, 2, 1, 0);
        add(0, 4'b0100, 4'b0000, 4'b0100, 2, 1, 0);
        add(0, 4'b0100, 4'b0100, 4'b0000, 2, 0, 0);
        add(0, 4'b1001, 4'b0000, 4'b1000, 3, 1, 0);
        add(0, 4'b1001, 4'b1000, 4'b0000, 3, 0, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 3, 0, 0);
        // Full contention, DONE on each owner's 2nd cycle: order 0,1,2,3,0.
        add(0, 4'b1111, 4'b0000, 4'b0001, 0, 1, 0);
        add(0, 4'b1111, 4'b0000, 4'b0001, 0, 1, 0);
        add(0, 4'b1111, 4'b0001, 4'b0000, 0, 0, 0);
        add(0, 4'b1111, 4'b0000, 4'b0010, 1, 1, 0);
        add(0, 4'b1111, 4'b0000, 4'b0010, 1, 1, 0);
        add(0, 4'b1111, 4'b0010, 4'b0000, 1, 0, 0);
        add(0, 4'b1111, 4'b0000, 4'b0100, 2, 1, 0);
        add(0, 4'b1111, 4'b0000, 4'b0100, 2, 1, 0);
        add(0, 4'b1111, 4'b0100, 4'b0000, 2, 0, 0);
        add(0, 4'b1111, 4'b0000, 4'b1000, 3, 1, 0);
        add(0, 4'b1111, 4'b0000, 4'b1000, 3, 1, 0);
        add(0, 4'b1111, 4'b1000, 4'b0000, 3, 0, 0);
        add(0, 4'b1111, 4'b0000, 4'b0001, 0, 1, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        // ptr is 1 here; grant 3, then reset mid-grant must restore ptr 0.
        add(0, 4'b1000, 4'b0000, 4'b1000, 3, 1, 0);
        add(0, 4'b1000, 4'b0000, 4'b1000, 3, 1, 0);
        add(1, 4'b1001, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b1001, 4'b0000, 4'b0001, 0, 1, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].done);
            check("vec", i, vecs[i].gnt, vecs[i].sel, vecs[i].busy, vecs[i].pre);
        end

        // Contended owner 0 never releases: exactly 8 owned cycles, then preempt.
        step(1, 4'b0000, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            step(0, 4'b0011, 4'b0000);
            check("hold", i, 4'b0001, 0, 1, 0);
        end
        step(0, 4'b0011, 4'b0000);
        check("preempt", 0, 4'b0000, 0, 0, 1);
        step(0, 4'b0011, 4'b0000);
        check("after_preempt", 0, 4'b0010, 1, 1, 0);
        step(0, 4'b0000, 4'b0000);
        check("preempt_rel", 0, 4'b0000, 1, 0, 0);

        // Uncontended owner keeps the grant indefinitely.
        step(1, 4'b0000, 4'b0000);
        for (int i = 0; i < 20; i++) begin
            step(0, 4'b0001, 4'b0000);
            check("solo", i, 4'b0001, 0, 1, 0);
        end
        step(0, 4'b0000, 4'b0000);
        check("solo_rel", 0, 4'b0000, 0, 0, 0);

        // DONE coinciding with the preemption point is an ordinary release.
        step(1, 4'b0000, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            step(0, 4'b0011, 4'b0000);
        end
        check("coinc_hold", 0, 4'b0001, 0, 1, 0);
        step(0, 4'b0011, 4'b0001);
        check("coinc_rel", 0, 4'b0000, 0, 0, 0);
        // DONE from the incoming requester during the gap is ignored.
        step(0, 4'b0011, 4'b0010);
        check("gap_done", 0, 4'b0010, 1, 1, 0);
        step(0, 4'b0011, 4'b0000);
        check("gap_done_hold", 0, 4'b0010, 1, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
